// File: rtl/shift_rx_serial_in_parallel_out.sv
// Serial-line receiver: start bit, WIDTH data bits MSB first, stop bit, word on a valid/ready port.
// Define SHIFT_RX_PARITY_EN to add an even-parity bit between data and stop, with a PERR pulse.
module shift_rx_serial_in_parallel_out #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic             CE,
  input  logic             SI,
  output logic [WIDTH-1:0] PO,
  output logic             VALID,
  input  logic             READY,
  output logic             FERR,
`ifdef SHIFT_RX_PARITY_EN
  output logic             PERR,
`endif
  output logic             OVR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
`ifdef SHIFT_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [WIDTH-1:0] r_po;
  logic             r_valid;
  logic             r_ferr;
  logic             r_ovr;
  logic             w_frame_good;
  logic             w_frame_ferr;
  logic             w_frame_perr;
  logic             w_par_ok;

`ifdef SHIFT_RX_PARITY_EN
  logic r_par, w_par_nxt;
  logic r_perr;

  assign w_par_ok = ~(^{r_shift, r_par});
  assign PERR     = r_perr;
`else
  assign w_par_ok = 1'b1;
`endif

  // Frame sequencing: everything here advances only on CE edges.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_frame_good = 1'b0;
    w_frame_ferr = 1'b0;
    w_frame_perr = 1'b0;
`ifdef SHIFT_RX_PARITY_EN
    w_par_nxt    = r_par;
`endif
    if (CE) begin
      case (r_state)
        S_IDLE: begin
          if (!SI) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = '0;
          end
        end
        S_DATA: begin
          w_shift_nxt = {r_shift[WIDTH-2:0], SI};
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef SHIFT_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
`ifdef SHIFT_RX_PARITY_EN
        S_PARITY: begin
          w_par_nxt   = SI;
          w_state_nxt = S_STOP;
        end
`endif
        S_STOP: begin
          w_state_nxt = S_IDLE;
          if (!SI)           w_frame_ferr = 1'b1;
          else if (!w_par_ok) w_frame_perr = 1'b1;
          else               w_frame_good = 1'b1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
`ifdef SHIFT_RX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
`ifdef SHIFT_RX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  // Output port: handshake and pulses run every clock, independent of CE.
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      r_po    <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef SHIFT_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_ferr <= w_frame_ferr;
      r_ovr  <= 1'b0;
`ifdef SHIFT_RX_PARITY_EN
      r_perr <= w_frame_perr;
`endif
      if (w_frame_good) begin
        // A consumer taking the old word in this same cycle frees the slot for the new one.
        if (!r_valid || READY) begin
          r_po    <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && READY) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifndef SHIFT_RX_PARITY_EN
  logic w_unused_perr;
  assign w_unused_perr = w_frame_perr;
`endif

  assign PO    = r_po;
  assign VALID = r_valid;
  assign FERR  = r_ferr;
  assign OVR   = r_ovr;

endmodule

// File: tb/tb_shift_rx_serial_in_parallel_out.sv
// Self-checking bench for shift_rx_serial_in_parallel_out: directed frame table, hand sequences,
// and random line activity against a frame-level reference model.
module tb_shift_rx_serial_in_parallel_out;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
`ifdef SHIFT_RX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 3;
`else
  localparam int FRAME_LEN = WIDTH + 2;
`endif

  logic             C;
  logic             CLR_N;
  logic             CE;
  logic             SI;
  logic [WIDTH-1:0] PO;
  logic             VALID;
  logic             READY;
  logic             FERR;
  logic             OVR;
`ifdef SHIFT_RX_PARITY_EN
  logic             PERR;
`endif

  shift_rx_serial_in_parallel_out #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .C     (C),
    .CLR_N (CLR_N),
    .CE    (CE),
    .SI    (SI),
    .PO    (PO),
    .VALID (VALID),
    .READY (READY),
    .FERR  (FERR),
`ifdef SHIFT_RX_PARITY_EN
    .PERR  (PERR),
`endif
    .OVR   (OVR)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects the sampled line bits of a frame, then judges the whole frame.
  bit               m_bits[$];
  logic [WIDTH-1:0] m_po;
  bit               m_valid, m_ferr, m_ovr, m_perr;

  function automatic void model_reset();
    m_bits.delete();
    m_po = '0;
    m_valid = 0; m_ferr = 0; m_ovr = 0; m_perr = 0;
  endfunction

  function automatic void model_update(input bit ce, input bit si, input bit rdy);
    int unsigned data;
    bit good;
    bit stop;
    bit par_ok;
    good = 0;
    m_ferr = 0; m_ovr = 0; m_perr = 0;
    if (ce && (m_bits.size() != 0 || si == 1'b0)) begin
      m_bits.push_back(si);
      if (m_bits.size() == FRAME_LEN) begin
        data = 0;
        for (int i = 1; i <= WIDTH; i++) data = data * 2 + m_bits[i];
        stop = m_bits[FRAME_LEN-1];
        par_ok = 1;
`ifdef SHIFT_RX_PARITY_EN
        par_ok = (($countones(data) + m_bits[WIDTH+1]) % 2) == 0;
`endif
        m_bits.delete();
        if (!stop)        m_ferr = 1;
        else if (!par_ok) m_perr = 1;
        else              good = 1;
        if (good) begin
          if (!m_valid || rdy) begin
            m_po = WIDTH'(data);
            m_valid = 1;
          end else begin
            m_ovr = 1;
          end
        end
      end
    end
    if (!good && m_valid && rdy) m_valid = 0;
  endfunction

  task automatic compare_model(input string tag);
    check({tag, " PO"},    32'(PO),    32'(m_po));
    check({tag, " VALID"}, 32'(VALID), 32'(m_valid));
    check({tag, " FERR"},  32'(FERR),  32'(m_ferr));
    check({tag, " OVR"},   32'(OVR),   32'(m_ovr));
`ifdef SHIFT_RX_PARITY_EN
    check({tag, " PERR"},  32'(PERR),  32'(m_perr));
`endif
  endtask

  task automatic step(input bit ce, input bit si, input bit rdy);
    @(negedge C);
    CE = ce; SI = si; READY = rdy;
    @(posedge C);
    model_update(ce, si, rdy);
    #1;
  endtask

  // One frame: start, data MSB first, [parity], stop; READY only asserted on the stop bit.
  task automatic send_frame(input logic [WIDTH-1:0] data, input bit stop, input bit par,
                            input bit rdy_stop, input int gap, input string tag);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = WIDTH - 1; i >= 0; i--) bits.push_back(data[i]);
`ifdef SHIFT_RX_PARITY_EN
    bits.push_back(par);
`else
    if (par) bits.push_back(1'b1);
    if (par) bits.pop_back();
`endif
    bits.push_back(stop);
    for (int b = 0; b < bits.size(); b++) begin
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 1'($urandom % 2), 1'b0);
        compare_model({tag, " gap"});
      end
      step(1'b1, bits[b], (b == bits.size() - 1) ? rdy_stop : 1'b0);
      compare_model(tag);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] data;
    bit               stop;
    bit               rdy;
    logic [WIDTH-1:0] exp_po;
    bit               exp_valid;
    bit               exp_ferr;
    bit               exp_ovr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{data: 8'h3C, stop: 1, rdy: 0, exp_po: 8'h3C, exp_valid: 1, exp_ferr: 0, exp_ovr: 0};
    vecs[1] = '{data: 8'hC3, stop: 1, rdy: 0, exp_po: 8'h3C, exp_valid: 1, exp_ferr: 0, exp_ovr: 1};
    vecs[2] = '{data: 8'hC3, stop: 1, rdy: 1, exp_po: 8'hC3, exp_valid: 1, exp_ferr: 0, exp_ovr: 0};
    vecs[3] = '{data: 8'h3C, stop: 0, rdy: 0, exp_po: 8'hC3, exp_valid: 1, exp_ferr: 1, exp_ovr: 0};
    vecs[4] = '{data: 8'h81, stop: 1, rdy: 1, exp_po: 8'h81, exp_valid: 1, exp_ferr: 0, exp_ovr: 0};

    CLR_N = 1'b0; CE = 1'b0; SI = 1'b1; READY = 1'b0;
    model_reset();
    repeat (2) @(negedge C);
    check("reset PO", 32'(PO), 32'h0);
    check("reset VALID", 32'(VALID), 32'h0);
    check("reset FERR", 32'(FERR), 32'h0);
    check("reset OVR", 32'(OVR), 32'h0);
    CLR_N = 1'b1;

    // Idle line never starts a frame.
    repeat (50) begin
      step(1'b1, 1'b1, 1'b0);
      compare_model("idle");
    end
    check("idle PO", 32'(PO), 32'h0);
    check("idle VALID", 32'(VALID), 32'h0);
    check("idle FERR", 32'(FERR), 32'h0);

    // Directed frame table.
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].data, vecs[v].stop, ^vecs[v].data, vecs[v].rdy, 0, $sformatf("vec%0d", v));
      check($sformatf("vec%0d tbl PO", v),    32'(PO),    32'(vecs[v].exp_po));
      check($sformatf("vec%0d tbl VALID", v), 32'(VALID), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d tbl FERR", v),  32'(FERR),  32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d tbl OVR", v),   32'(OVR),   32'(vecs[v].exp_ovr));
      step(1'b1, 1'b1, 1'b0);
      compare_model($sformatf("vec%0d after", v));
      check($sformatf("vec%0d pulse end FERR", v), 32'(FERR), 32'h0);
      check($sformatf("vec%0d pulse end OVR", v),  32'(OVR),  32'h0);
    end

    // Handshake drain; PO retained; READY ignored while empty.
    step(1'b1, 1'b1, 1'b1);
    check("drain VALID", 32'(VALID), 32'h0);
    check("drain PO kept", 32'(PO), 32'h81);
    step(1'b1, 1'b1, 1'b1);
    compare_model("ready idle");

    // 0xA5 with READY low; VALID drops the cycle after READY.
    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0, 0, "a5");
    check("a5 PO", 32'(PO), 32'hA5);
    check("a5 VALID", 32'(VALID), 32'h1);
    step(1'b1, 1'b1, 1'b0);
    check("a5 held VALID", 32'(VALID), 32'h1);
    step(1'b1, 1'b1, 1'b1);
    check("a5 taken VALID", 32'(VALID), 32'h0);
    check("a5 taken PO", 32'(PO), 32'hA5);

    // Reset in the middle of a frame while a word is held.
    send_frame(8'h3C, 1'b1, ^8'h3C, 1'b0, 0, "pre rst");
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'(i % 2), 1'b0);
    @(negedge C);
    CLR_N = 1'b0;
    #1;
    check("midrst PO", 32'(PO), 32'h0);
    check("midrst VALID", 32'(VALID), 32'h0);
    check("midrst FERR", 32'(FERR), 32'h0);
    check("midrst OVR", 32'(OVR), 32'h0);
    model_reset();
    @(negedge C);
    CLR_N = 1'b1;
    send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0, 0, "post rst");
    check("post rst PO", 32'(PO), 32'h5A);
    check("post rst VALID", 32'(VALID), 32'h1);
    step(1'b1, 1'b1, 1'b1);
    compare_model("post rst drain");

    // CE gapped to one edge in three; pulses must still last one clock.
`ifdef SHIFT_RX_PARITY_EN
    for (int g = 0; g <= 2; g += 2) begin
      send_frame(8'h07, 1'b1, 1'b1, 1'b0, g, "par good");
      check($sformatf("par good g%0d VALID", g), 32'(VALID), 32'h1);
      check($sformatf("par good g%0d PO", g), 32'(PO), 32'h07);
      check($sformatf("par good g%0d PERR", g), 32'(PERR), 32'h0);
      step(1'b0, 1'b1, 1'b1);
      check($sformatf("par drain g%0d VALID", g), 32'(VALID), 32'h0);
      send_frame(8'h07, 1'b1, 1'b0, 1'b0, g, "par bad");
      check($sformatf("par bad g%0d PERR", g), 32'(PERR), 32'h1);
      check($sformatf("par bad g%0d VALID", g), 32'(VALID), 32'h0);
      check($sformatf("par bad g%0d OVR", g), 32'(OVR), 32'h0);
      step(1'b0, 1'b1, 1'b0);
      check($sformatf("par bad g%0d PERR end", g), 32'(PERR), 32'h0);
      send_frame(8'h07, 1'b0, 1'b0, 1'b0, g, "par ferr");
      check($sformatf("par ferr g%0d FERR", g), 32'(FERR), 32'h1);
      check($sformatf("par ferr g%0d PERR", g), 32'(PERR), 32'h0);
      step(1'b0, 1'b1, 1'b0);
      compare_model("par ferr end");
    end
`else
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 2, "gap good");
    check("gap good VALID", 32'(VALID), 32'h1);
    check("gap good PO", 32'(PO), 32'h07);
    step(1'b0, 1'b1, 1'b1);
    check("gap drain VALID", 32'(VALID), 32'h0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 2, "gap ferr");
    check("gap ferr FERR", 32'(FERR), 32'h1);
    check("gap ferr VALID", 32'(VALID), 32'h0);
    step(1'b0, 1'b1, 1'b0);
    check("gap ferr FERR end", 32'(FERR), 32'h0);
`endif

    // Random line activity against the frame-level model.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom % 4 != 0), 1'($urandom % 2), 1'($urandom % 3 == 0));
      compare_model("rand");
      check("rand FERR&OVR", 32'(FERR & OVR), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
